demux_1_to_2: RTL and testbench

Buffered 1-to-2 stream demultiplexer, the inverse of the datapath 2-to-1 select mux: one N-bit input stream is steered to one of two output streams by a per-word selector, with valid/ready handshakes on every side. Each output owns a 2-entry FIFO, so a stalled consumer on one channel blocks only words destined for that channel, and back-to-back words to an unstalled channel move at one word per cycle. It sits between the writeback/result producers and the two downstream consumers (e.g. register-file write port and memory-store path).

---
 rtl/demux_1_to_2.sv | 72 +++++++
 tb/tb_demux_1_to_2.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/demux_1_to_2.sv
// demux_1_to_2: buffered 1-to-2 stream demultiplexer with a 2-entry FIFO per output channel.
//   Parameter N  : data width (default 32).
//   clk, rstb    : rising-edge clock, asynchronous active-low reset.
//   in_*         : input stream (valid/ready/sel/data); in_sel picks channel 0 or 1.
//   out0_*/out1_*: output streams (valid/ready/data), head word of each channel FIFO.
//   count0/1     : words accepted per channel when DEMUX_1_TO_2_COUNT_EN is defined, else 0.
module demux_1_to_2 #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_sel,
   input  logic [N-1:0] in_data,
   output logic         out0_valid,
   input  logic         out0_ready,
   output logic [N-1:0] out0_data,
   output logic         out1_valid,
   input  logic         out1_ready,
   output logic [N-1:0] out1_data,
   output logic [15:0]  count0,
   output logic [15:0]  count1
);
   logic [N-1:0] mem [2][2];
   logic [1:0]   cnt [2];
   logic [1:0]   wr, rd, push, pop, valid, ready;
   // in_ready looks only at the selected FIFO's occupancy, never at the consumers' ready
   assign in_ready   = rstb & (cnt[in_sel] != 2'd2);
   assign push       = {in_valid & in_ready & in_sel, in_valid & in_ready & ~in_sel};
   assign valid      = {cnt[1] != 2'd0, cnt[0] != 2'd0};
   assign ready      = {out1_ready, out0_ready};
   assign pop        = valid & ready;
   assign out0_valid = valid[0];
   assign out1_valid = valid[1];
   assign out0_data  = mem[0][rd[0]];
   assign out1_data  = mem[1][rd[1]];
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int k = 0; k < 2; k++) begin
            mem[k][0] <= '0;
            mem[k][1] <= '0;
            cnt[k]    <= '0;
         end
         wr <= '0;
         rd <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
               mem[k][wr[k]] <= in_data;
               wr[k]         <= ~wr[k];
            end
            if (pop[k]) rd[k] <= ~rd[k];
            cnt[k] <= cnt[k] + 2'(push[k]) - 2'(pop[k]);
         end
      end
   end
`ifdef DEMUX_1_TO_2_COUNT_EN
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         count0 <= '0;
         count1 <= '0;
      end else begin
         count0 <= count0 + 16'(push[0]);
         count1 <= count1 + 16'(push[1]);
      end
   end
`else
   assign count0 = '0;
   assign count1 = '0;
`endif
endmodule

// File: tb/tb_demux_1_to_2.sv
// tb_demux_1_to_2: directed and scoreboarded checks of demux_1_to_2 (count checks follow DEMUX_1_TO_2_COUNT_EN).
module tb_demux_1_to_2;
   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic        in_valid = 1'b0, in_ready, in_sel = 1'b0;
   logic [31:0] in_data = '0;
   logic        out0_valid, out0_ready = 1'b0, out1_valid, out1_ready = 1'b0;
   logic [31:0] out0_data, out1_data;
   logic [15:0] count0, count1;
   logic [31:0] q0[$], q1[$];
   logic [15:0] c0 = '0, c1 = '0;
   int          checks = 0, errors = 0;

   demux_1_to_2 #(.N(32)) dut (
      .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
      .in_data(in_data), .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
      .count0(count0), .count1(count1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_cnt(input logic [15:0] c);
`ifdef DEMUX_1_TO_2_COUNT_EN
      return c;
`else
      return 16'h0000 & c;
`endif
   endfunction

   // compare every output against the queue model, then advance one clock and update the model
   task automatic tick();
      logic rdy;
      #1;
      rdy = rstb && ((in_sel ? q1.size() : q0.size()) != 2);
      chk("in_ready", in_ready, rdy);
      chk("out0_valid", out0_valid, q0.size() != 0);
      chk("out1_valid", out1_valid, q1.size() != 0);
      if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
      if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
      chk("count0", count0, exp_cnt(c0));
      chk("count1", count1, exp_cnt(c1));
      if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
      if (in_valid && rdy) begin
         if (in_sel) begin q1.push_back(in_data); c1++; end
         else begin q0.push_back(in_data); c0++; end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [31:0] d, input logic r0, input logic r1);
      in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #4;
      rstb = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out0_valid", out0_valid, 0);
      chk("rst_out1_valid", out1_valid, 0);
      chk("rst_out0_data", out0_data, 0);
      chk("rst_out1_data", out1_data, 0);
      chk("rst_count0", count0, 0);
      q0.delete(); q1.delete(); c0 = '0; c1 = '0;
      @(negedge clk);
      rstb = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset release, one word to channel 0
      #12 rstb = 1'b1;
      @(posedge clk); #1;
      drive(1, 0, 32'hDEADBEEF, 1, 0);
      #1 chk("t1_in_ready", in_ready, 1);
      tick();
      drive(0, 0, 0, 1, 0);
      chk("t1_out0_valid", out0_valid, 1);
      chk("t1_out0_data", out0_data, 32'hDEADBEEF);
      chk("t1_out1_valid", out1_valid, 0);
      tick();
      // channel 1 stalled: two accepted, third blocked until a pop frees a slot
      drive(1, 1, 32'h1, 0, 0); tick();
      drive(1, 1, 32'h2, 0, 0); tick();
      drive(1, 1, 32'h3, 0, 0);
      #1 chk("t2_full_block", in_ready, 0);
      tick();
      drive(1, 1, 32'h3, 0, 1);
      chk("t2_head1", out1_data, 32'h1);
      tick();
      chk("t2_head2", out1_data, 32'h2);
      chk("t2_ready_again", in_ready, 1);
      tick();
      drive(0, 0, 0, 0, 1);
      chk("t2_head3", out1_data, 32'h3);
      tick();
      tick();
      // channel 1 full and stalled, alternating destinations
      drive(1, 1, 32'hA1, 1, 0); tick();
      drive(1, 1, 32'hA2, 1, 0); tick();
      for (int i = 0; i < 8; i++) begin
         drive(1, i[0], 32'hC0 + i, 1, 0);
         #1 chk("t3_ready_alt", in_ready, !i[0]);
         tick();
      end
      drive(1, 0, 32'hC8, 1, 0); tick();
      drive(1, 0, 32'hC9, 1, 0);
      chk("t3_stream", out0_data, 32'hC8);
      tick();
      drive(0, 0, 0, 1, 1); tick(); tick(); tick();
      // channel 0 holding one word, simultaneous push and pop
      drive(1, 0, 32'h55, 0, 0); tick();
      drive(1, 0, 32'h66, 1, 0); tick();
      drive(0, 0, 0, 0, 0);
      chk("t4_valid", out0_valid, 1);
      chk("t4_head", out0_data, 32'h66);
      tick();
      // random traffic against the queue model
      for (int i = 0; i < 100; i++) begin
         drive(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
         tick();
      end
      // fill both channels, then reset asynchronously
      drive(0, 0, 0, 1, 1); tick(); tick(); tick();
      drive(1, 0, 32'hF0, 0, 0); tick();
      drive(1, 0, 32'hF1, 0, 0); tick();
      drive(1, 1, 32'hF2, 0, 0); tick();
      drive(1, 1, 32'hF3, 0, 0); tick();
      drive(0, 0, 0, 1, 1);
      do_reset();
      tick(); tick();
      // counter wrap on channel 0
      do_reset();
      for (int i = 0; i < 65537; i++) begin
         drive(1, 0, 32'(i), 1, 0);
         @(posedge clk); #1;
      end
      c0 = c0 + 16'(65537 & 16'hFFFF);
      q0.delete();
      q0.push_back(32'(65536));
      drive(0, 0, 0, 1, 0);
      chk("t6_count0", count0, exp_cnt(16'h0001));
      chk("t6_count1", count1, 0);
      chk("t6_last", out0_data, 32'(65536));
      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
